synth_frame_sched: RTL and testbench

Per-sample frame scheduler for the synth engine clock generator. Derives the 44.1 kHz sample tick from `AUDIO_CLK` with a phase accumulator and issues the `trig` pulse that starts one voice/envelope scan in `synth_clk_gen`. Tracks completion of that scan through `xxxx`/`xxxx_zero` and hands a completed-frame strobe to the output stage with a valid/ready handshake. Detects overruns (a tick arrives while a frame is still in flight) and stalled scans (watchdog timeout).

---
 rtl/synth_frame_sched_pkg.sv | 29 ++
 rtl/synth_frame_sched_nco.sv | 27 ++
 rtl/synth_frame_sched.sv | 133 +++++++++++++
 tb/tb_synth_frame_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_frame_sched_pkg.sv
// Shared types and constants for the synth frame scheduler, plus the small
// sizing helper used across the synth blocks.
package utils;
  function automatic int clogb2(input int unsigned n);
    int unsigned v;
    clogb2 = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      clogb2++;
    end
  endfunction
endpackage

package synth_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_HAND
  } frame_state_t;

  // 2^24 * 44100 / 90416666 rounded
  localparam int SYNTH_PHASE_INC = 8183;
  localparam int SYNTH_TRIG_LEN  = 4;
  localparam int OVR_CNT_W       = 16;
endpackage

// File: rtl/synth_frame_sched_nco.sv
// Phase-accumulator strobe generator: one registered tick per accumulator wrap.
module sample_nco #(
  parameter int ACC_WIDTH = 24,
  parameter int PHASE_INC = 8183
) (
  input  logic AUDIO_CLK,
  input  logic reset_reg_N,
  input  logic enable,
  output logic sample_tick
);
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(PHASE_INC);

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      acc         <= '0;
      sample_tick <= 1'b0;
    end else if (enable) begin
      acc         <= sum[ACC_WIDTH-1:0];
      sample_tick <= sum[ACC_WIDTH];
    end else begin
      sample_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/synth_frame_sched.sv
// Per-sample frame scheduler: fires trig on each sample tick, tracks the scan
// to completion, hands the frame off, and flags overruns and stalled scans.
module synth_frame_sched
  import synth_pkg::*;
#(
  parameter int VOICES    = 8,
  parameter int V_WIDTH   = 3,
  parameter int E_WIDTH   = 3,
  parameter int ACC_WIDTH = 24,
  parameter int PHASE_INC = SYNTH_PHASE_INC,
  parameter int TRIG_LEN  = SYNTH_TRIG_LEN,
  parameter int TIMEOUT   = 4096
) (
  input  logic                       AUDIO_CLK,
  input  logic                       reset_reg_N,
  input  logic                       enable,
  input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  input  logic                       xxxx_zero,
  input  logic                       out_ready,
  input  logic                       clr_status,
  output logic                       trig,
  output logic                       sample_tick,
  output logic                       frame_busy,
  output logic                       frame_valid,
  output logic                       overrun,
  output logic                       timeout_err,
  output logic [OVR_CNT_W-1:0]       overrun_cnt
);
  localparam int IW   = V_WIDTH + E_WIDTH;
  localparam int TC_W = utils::clogb2(TRIG_LEN + 1);
  localparam int WD_W = utils::clogb2(TIMEOUT + 1);
  localparam logic [TC_W-1:0]      TC_LOAD = TC_W'(TRIG_LEN);
  localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [OVR_CNT_W-1:0] CNT_MAX = '1;

  frame_state_t    state;
  logic [TC_W-1:0] tcnt;   // trig length, then reused for the drain delay
  logic [WD_W-1:0] wd;
  logic            zero_q, idx_nz_q, walked;
  logic            in_flight, wd_hit, zero_rise, overrun_ev;

  sample_nco #(.ACC_WIDTH(ACC_WIDTH), .PHASE_INC(PHASE_INC)) u_nco (
    .AUDIO_CLK  (AUDIO_CLK),
    .reset_reg_N(reset_reg_N),
    .enable     (enable),
    .sample_tick(sample_tick)
  );

  assign in_flight  = state inside {ST_TRIG, ST_ARM, ST_RUN};
  assign wd_hit     = in_flight && (wd == WD_LAST);
  assign zero_rise  = xxxx_zero && !zero_q;
  assign overrun_ev = sample_tick && (state != ST_IDLE);

  // Watchdog runs from trig start, so the TRIG cycles count toward TIMEOUT.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      wd          <= '0;
      zero_q      <= 1'b0;
      idx_nz_q    <= 1'b0;
      walked      <= 1'b0;
      trig        <= 1'b0;
      frame_busy  <= 1'b0;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      zero_q   <= xxxx_zero;
      idx_nz_q <= (xxxx != '0) && (int'(xxxx[IW-1:E_WIDTH]) < VOICES);
      if (clr_status) timeout_err <= 1'b0;
      if (in_flight) wd <= wd + 1'b1;
      case (state)
        ST_IDLE: if (sample_tick) begin
          state      <= ST_TRIG;
          tcnt       <= TC_LOAD;
          wd         <= '0;
          walked     <= 1'b0;
          trig       <= 1'b1;
          frame_busy <= 1'b1;
        end
        ST_TRIG: if (tcnt == TC_W'(1)) begin
          state <= ST_ARM;
          trig  <= 1'b0;
        end else begin
          tcnt <= tcnt - 1'b1;
        end
        // A zero still showing on entry is the previous scan's; wait it out.
        ST_ARM: if (!xxxx_zero) begin
          state  <= ST_RUN;
          walked <= 1'b1;
        end
        ST_RUN: if (zero_rise && (idx_nz_q || walked)) begin
          state <= ST_DRAIN;
          tcnt  <= TC_W'(2);
        end
        ST_DRAIN: if (tcnt == TC_W'(1)) begin
          state       <= ST_HAND;
          frame_valid <= 1'b1;
        end else begin
          tcnt <= tcnt - 1'b1;
        end
        ST_HAND: if (out_ready) begin
          state       <= ST_IDLE;
          frame_valid <= 1'b0;
          frame_busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      // A stalled scan is still handed off so the output stage never waits forever.
      if (wd_hit) begin
        state       <= ST_HAND;
        trig        <= 1'b0;
        frame_valid <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end

  // A new overrun wins over a same-cycle clear and restarts the count at 1.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (overrun_ev) begin
      overrun <= 1'b1;
      if (clr_status)                overrun_cnt <= OVR_CNT_W'(1);
      else if (overrun_cnt != CNT_MAX) overrun_cnt <= overrun_cnt + 1'b1;
    end else if (clr_status) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_synth_frame_sched.sv
// Bench for synth_frame_sched: a nominal-rate instance for frame behaviour and a
// fast-tick instance for counter saturation, both run against a tick-count model.
module tb_synth_frame_sched;
  localparam longint INC   = 8183;
  localparam longint INC_B = 255;

  logic AUDIO_CLK = 1'b0;
  logic reset_reg_N = 1'b0, enable = 1'b0, xxxx_zero = 1'b1, out_ready = 1'b1, clr_status = 1'b0;
  logic [5:0] xxxx = '0;
  logic trig, sample_tick, frame_busy, frame_valid, overrun, timeout_err;
  logic [15:0] overrun_cnt;

  logic rst_b = 1'b0, en_b = 1'b1, zero_b = 1'b1, ready_b = 1'b0, clr_b = 1'b0;
  logic [5:0] xxxx_b = '0;
  logic trig_b, tick_b, busy_b, valid_b, ovr_b, terr_b;
  logic [15:0] cnt_b;

  int vectors = 0, miscompares = 0;

  always #5 AUDIO_CLK = ~AUDIO_CLK;

  synth_frame_sched dut (
    .AUDIO_CLK(AUDIO_CLK), .reset_reg_N(reset_reg_N), .enable(enable), .xxxx(xxxx),
    .xxxx_zero(xxxx_zero), .out_ready(out_ready), .clr_status(clr_status), .trig(trig),
    .sample_tick(sample_tick), .frame_busy(frame_busy), .frame_valid(frame_valid),
    .overrun(overrun), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );

  synth_frame_sched #(.ACC_WIDTH(8), .PHASE_INC(255), .TIMEOUT(16)) dut_b (
    .AUDIO_CLK(AUDIO_CLK), .reset_reg_N(rst_b), .enable(en_b), .xxxx(xxxx_b),
    .xxxx_zero(zero_b), .out_ready(ready_b), .clr_status(clr_b), .trig(trig_b),
    .sample_tick(tick_b), .frame_busy(busy_b), .frame_valid(valid_b),
    .overrun(ovr_b), .timeout_err(terr_b), .overrun_cnt(cnt_b)
  );

  // Reference: a tick is due on every enabled edge where the running phase
  // total (edges * increment) crosses a multiple of the accumulator modulus.
  longint n_en = 0, n_b = 0;
  logic   exp_tick = 1'b0;
  always @(posedge AUDIO_CLK or negedge reset_reg_N)
    if (!reset_reg_N) begin
      n_en <= 0; exp_tick <= 1'b0;
    end else if (enable) begin
      n_en     <= n_en + 1;
      exp_tick <= (((n_en + 1) * INC) >> 24) != ((n_en * INC) >> 24);
    end else begin
      exp_tick <= 1'b0;
    end

  always @(posedge AUDIO_CLK or negedge rst_b)
    if (!rst_b) n_b <= 0;
    else        n_b <= n_b + 1;

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge AUDIO_CLK);
  endtask

  task automatic do_reset();
    reset_reg_N = 1'b0;
    cyc(2);
    reset_reg_N = 1'b1;
  endtask

  // Advance to the next negedge where the model says a tick is visible.
  task automatic wait_tick();
    for (int i = 0; i < 2200; i++) begin
      cyc();
      if (exp_tick) return;
    end
    vectors++; miscompares++;
    $display("FAIL wait_tick: no model tick within 2200 cycles");
  endtask

  task automatic test_reset();
    cyc(2);
    vectors++;
    if ({trig, sample_tick, frame_busy, frame_valid, overrun, timeout_err, overrun_cnt} !== 22'd0) begin
      miscompares++; $display("FAIL reset_values: got %h want 0",
        {trig, sample_tick, frame_busy, frame_valid, overrun, timeout_err, overrun_cnt});
    end
    reset_reg_N = 1'b1;
    cyc(50);
    vectors++;
    if ({trig, sample_tick, frame_busy} !== 3'b000) begin
      miscompares++; $display("FAIL disabled_idle: got %b want 000", {trig, sample_tick, frame_busy});
    end
  endtask

  task automatic test_tick_rate();
    int last = -1, seen = 0;
    longint n0, exp_n;
    enable = 1'b1; xxxx_zero = 1'b1; out_ready = 1'b1;
    n0 = n_en;
    for (int c = 0; c < 6200; c++) begin
      cyc();
      vectors++;
      if (sample_tick !== exp_tick) begin
        miscompares++; $display("FAIL tick_model c=%0d: got %b want %b", c, sample_tick, exp_tick);
      end
      if (sample_tick === 1'b1) begin
        if (last >= 0) begin
          vectors++;
          if (c - last != 2050 && c - last != 2051) begin
            miscompares++; $display("FAIL tick_interval: got %0d want 2050/2051", c - last);
          end
        end
        last = c; seen++;
      end
    end
    exp_n = ((n_en * INC) >> 24) - ((n0 * INC) >> 24);
    vectors++;
    if (longint'(seen) != exp_n) begin
      miscompares++; $display("FAIL tick_count: got %0d want %0d", seen, exp_n);
    end
    do_reset();
  endtask

  task automatic test_nominal();
    int len, hold;
    for (int f = 0; f < 2; f++) begin
      len = $urandom_range(100, 400); hold = $urandom_range(1, 20);
      xxxx_zero = 1'b1; xxxx = '0; out_ready = 1'b0;
      wait_tick();
      vectors++;
      if (sample_tick !== 1'b1) begin
        miscompares++; $display("FAIL nominal_tick: got %b want 1", sample_tick);
      end
      for (int i = 0; i <= 6; i++) begin
        if (i > 0) cyc();
        vectors++;
        if (trig !== (i >= 1 && i <= 4)) begin
          miscompares++; $display("FAIL trig_shape i=%0d: got %b want %b", i, trig, (i >= 1 && i <= 4));
        end
        if (i == 5) xxxx_zero = 1'b0;
      end
      for (int j = 0; j < len; j++) begin
        cyc();
        xxxx = 6'($urandom_range(1, 63));
      end
      vectors++;
      if ({frame_busy, frame_valid} !== 2'b10) begin
        miscompares++; $display("FAIL nominal_run: got %b want 10", {frame_busy, frame_valid});
      end
      xxxx_zero = 1'b1; xxxx = '0;
      cyc(2);
      vectors++;
      if (frame_valid !== 1'b0) begin
        miscompares++; $display("FAIL valid_early: got %b want 0", frame_valid);
      end
      cyc();
      vectors++;
      if (frame_valid !== 1'b1) begin
        miscompares++; $display("FAIL valid_latency: got %b want 1", frame_valid);
      end
      cyc(hold);
      vectors++;
      if ({frame_valid, frame_busy} !== 2'b11) begin
        miscompares++; $display("FAIL valid_hold: got %b want 11", {frame_valid, frame_busy});
      end
      out_ready = 1'b1;
      cyc();
      vectors++;
      if ({frame_valid, frame_busy, overrun} !== 3'b000) begin
        miscompares++; $display("FAIL handoff: got %b want 000", {frame_valid, frame_busy, overrun});
      end
    end
  endtask

  task automatic test_stall();
    int n_ovr = 0, drops = 0;
    clr_status = 1'b1; cyc(); clr_status = 1'b0;
    xxxx_zero = 1'b1; out_ready = 1'b0;
    wait_tick();
    cyc(5); xxxx_zero = 1'b0;
    cyc(50); xxxx_zero = 1'b1;
    cyc(3);
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (exp_tick) n_ovr++;
      if (frame_valid !== 1'b1) drops++;
    end
    vectors++;
    if (drops != 0) begin
      miscompares++; $display("FAIL stall_valid: got %0d drops want 0", drops);
    end
    vectors++;
    if (overrun !== (n_ovr > 0) || overrun_cnt !== 16'(n_ovr)) begin
      miscompares++; $display("FAIL stall_overrun: got %b/%0d want %b/%0d", overrun, overrun_cnt, n_ovr > 0, n_ovr);
    end
    // Accept on a tick cycle: that tick is an overrun and must not start a frame.
    wait_tick(); n_ovr++;
    out_ready = 1'b1;
    cyc();
    vectors++;
    if (frame_valid !== 1'b0 || overrun_cnt !== 16'(n_ovr)) begin
      miscompares++; $display("FAIL accept_tick: got %b/%0d want 0/%0d", frame_valid, overrun_cnt, n_ovr);
    end
    cyc();
    vectors++;
    if ({trig, frame_busy} !== 2'b00) begin
      miscompares++; $display("FAIL dropped_tick: got %b want 00", {trig, frame_busy});
    end
  endtask

  task automatic test_watchdog();
    clr_status = 1'b1; cyc(); clr_status = 1'b0;
    vectors++;
    if ({overrun, timeout_err, overrun_cnt} !== 18'd0) begin
      miscompares++; $display("FAIL clr_status: got %h want 0", {overrun, timeout_err, overrun_cnt});
    end
    out_ready = 1'b0; xxxx_zero = 1'b1;
    wait_tick();
    cyc();
    vectors++;
    if (trig !== 1'b1) begin
      miscompares++; $display("FAIL wd_trig: got %b want 1", trig);
    end
    cyc(4); xxxx_zero = 1'b0;
    cyc(4091);
    vectors++;
    if ({timeout_err, frame_valid} !== 2'b00) begin
      miscompares++; $display("FAIL wd_early: got %b want 00", {timeout_err, frame_valid});
    end
    cyc();
    vectors++;
    if ({timeout_err, frame_valid, frame_busy} !== 3'b111) begin
      miscompares++; $display("FAIL wd_fire: got %b want 111", {timeout_err, frame_valid, frame_busy});
    end
    out_ready = 1'b1; xxxx_zero = 1'b1;
    cyc();
    vectors++;
    if ({timeout_err, frame_valid} !== 2'b10) begin
      miscompares++; $display("FAIL wd_sticky: got %b want 10", {timeout_err, frame_valid});
    end
    clr_status = 1'b1; cyc(); clr_status = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL wd_clear: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid_run();
    int early = 0;
    bit hit = 1'b0;
    do_reset();
    xxxx_zero = 1'b1; out_ready = 1'b1;
    wait_tick();
    cyc(5); xxxx_zero = 1'b0;
    cyc(30);
    vectors++;
    if (frame_busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_run_busy: got %b want 1", frame_busy);
    end
    #2 reset_reg_N = 1'b0;
    #1;
    vectors++;
    if ({trig, sample_tick, frame_busy, frame_valid, overrun, timeout_err, overrun_cnt} !== 22'd0) begin
      miscompares++; $display("FAIL async_reset: got %h want 0",
        {trig, sample_tick, frame_busy, frame_valid, overrun, timeout_err, overrun_cnt});
    end
    cyc(3);
    reset_reg_N = 1'b1; xxxx_zero = 1'b1;
    for (int i = 0; i < 2200 && !hit; i++) begin
      cyc();
      if (exp_tick) hit = 1'b1;
      else if (trig !== 1'b0) early++;
    end
    vectors++;
    if (!hit || early != 0 || sample_tick !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_tick: got hit=%b early=%0d tick=%b want 1/0/1", hit, early, sample_tick);
    end
    cyc();
    vectors++;
    if (trig !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_trig: got %b want 1", trig);
    end
  endtask

  // Fast-tick instance: with out_ready low the first tick's frame parks in
  // HAND, so every later consumed tick is an overrun.
  task automatic test_saturate();
    longint c, e;
    cyc(2); rst_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(k == 0 ? 1000 : 66500);
      c = ((n_b - 1) * INC_B) >> 8;
      e = (c > 0) ? c - 1 : 0;
      if (e > 65535) e = 65535;
      vectors++;
      if (cnt_b !== 16'(e) || ovr_b !== 1'b1) begin
        miscompares++; $display("FAIL sat_count k=%0d: got %0d/%b want %0d/1", k, cnt_b, ovr_b, e);
      end
    end
    for (int i = 0; i < 300 && tick_b !== 1'b1; i++) cyc();
    clr_b = 1'b1; cyc(); clr_b = 1'b0;
    vectors++;
    if ({ovr_b, terr_b} !== 2'b10 || cnt_b !== 16'd1) begin
      miscompares++; $display("FAIL clr_with_overrun: got %b/%0d want 10/1", {ovr_b, terr_b}, cnt_b);
    end
    for (int i = 0; i < 300 && tick_b !== 1'b0; i++) cyc();
    clr_b = 1'b1; cyc(); clr_b = 1'b0;
    vectors++;
    if (ovr_b !== 1'b0 || cnt_b !== 16'd0) begin
      miscompares++; $display("FAIL clr_quiet: got %b/%0d want 0/0", ovr_b, cnt_b);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    fork
      begin
        test_reset();
        test_tick_rate();
        test_nominal();
        test_stall();
        test_watchdog();
        test_reset_mid_run();
      end
      test_saturate();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
